pipeline_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB stage registers).
- Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Drives per-stage write enables and bubble/flush controls, and keeps saturating performance counters.
- Contains a memory-wait FSM with timeout and a sticky error state.

---
 rtl/pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Decodes load-use, taken-branch and memory-wait hazards into per-stage
// enables and bubble/flush controls, and counts stall and flush cycles.
//
// Ports:
//   clock, reset     : single clock; synchronous active-high reset
//   ifid_rs/rt       : source fields of the instruction in IF/ID
//   ifid_uses_rt     : IF/ID instruction reads rt as a source
//   idex_mem_read    : instruction in ID/EX is a load
//   idex_rt          : load destination held in ID/EX
//   branch_taken     : branch/jump in EX resolved taken
//   mem_req          : EX/MEM holds a load or store
//   mem_ready        : data memory completes the access this cycle
//   pc_write..memwb_bubble : pipeline register controls (combinational)
//   mem_error        : sticky timeout flag, cleared only by reset
//   stall_cycles     : saturating count of cycles with pc_write=0
//   flush_events     : saturating count of cycles with ifid_flush=1
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;

    logic in_error;
    logic freeze;
    logic load_use;

    logic sel_rst;
    logic sel_err;
    logic sel_frz;
    logic sel_br;
    logic sel_lu;

    logic stall_inc;
    logic flush_inc;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign in_error = (state == ERROR);

    // freeze excludes ERROR so a dead pipeline never re-enters the wait path
    assign freeze = !in_error && mem_req && !mem_ready;

    // r0 is hard-wired zero, so a load into it is never a real dependency
    assign load_use = idex_mem_read
                   && (idex_rt != 5'd0)
                   && ((idex_rt == ifid_rs)
                    || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Mutually exclusive selectors encode the output priority
    assign sel_rst = reset;
    assign sel_err = !reset && in_error;
    assign sel_frz = !reset && freeze;
    assign sel_br  = !reset && !in_error && !freeze && branch_taken;
    assign sel_lu  = !reset && !in_error && !freeze && !branch_taken
                   && load_use;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        unique case (1'b1)
            sel_rst, sel_err: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
            end
            sel_frz: begin
                // Whole pipeline holds; a pending branch stays in ID/EX
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end
            sel_br: begin
                // Flushing the consumer makes any load-use moot
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            sel_lu: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    assign mem_error = in_error;

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cnt == TMO) begin
                        state_nxt = ERROR;
                    end else begin
                        wait_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = 8'd0;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    assign stall_inc = !reset && !in_error && !pc_write;
    assign flush_inc = ifid_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_inc && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    ifid_rs;
    logic [4:0]    ifid_rt;
    logic          ifid_uses_rt;
    logic          idex_mem_read;
    logic [4:0]    idex_rt;
    logic          branch_taken;
    logic          mem_req;
    logic          mem_ready;
    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_write;
    logic          idex_bubble;
    logic          exmem_write;
    logic          memwb_bubble;
    logic          mem_error;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_mem_read(idex_mem_read),
        .idex_rt      (idex_rt),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_write  (exmem_write),
        .memwb_bubble (memwb_bubble),
        .mem_error    (mem_error),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: error flag, length of the current run of frozen
    // cycles, and the two counters.
    bit m_err;
    int m_frozen_run;
    int m_stall;
    int m_flush;

    initial begin
        m_err = 0;
        m_frozen_run = 0;
        m_stall = 0;
        m_flush = 0;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit frz;
            bit lu;
            bit [6:0] e;
            bit [6:0] a;
            frz = mem_req && !mem_ready;
            lu = idex_mem_read && idex_rt != 0 &&
                 (idex_rt == ifid_rs ||
                  (ifid_uses_rt && idex_rt == ifid_rt));
            // e = {pc, ifid_w, flush, idex_w, bubble, exmem_w, memwb_bub}
            if (reset || m_err) e = 7'b0000101;
            else if (frz)       e = 7'b0000001;
            else if (branch_taken) e = 7'b1111110;
            else if (lu)        e = 7'b0001110;
            else                e = 7'b1101010;
            a = {pc_write, ifid_write, ifid_flush, idex_write,
                 idex_bubble, exmem_write, memwb_bubble};
            chk("controls", int'(a), int'(e));
            chk("mem_error", int'(mem_error), int'(m_err));
            chk("stall_cycles", int'(stall_cycles), m_stall);
            chk("flush_events", int'(flush_events), m_flush);
            if (reset) begin
                m_err = 0;
                m_frozen_run = 0;
                m_stall = 0;
                m_flush = 0;
            end else if (!m_err) begin
                if (!e[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                if (e[4])  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                if (frz) begin
                    m_frozen_run++;
                    if (m_frozen_run > TMO) m_err = 1;
                end else begin
                    m_frozen_run = 0;
                end
            end
        end
    end

    task automatic set_in(input bit r, input int rs, input int rt,
                          input bit urt, input bit mr, input int irt,
                          input bit br, input bit mq, input bit mrdy);
        reset = r;
        ifid_rs = 5'(rs);
        ifid_rt = 5'(rt);
        ifid_uses_rt = urt;
        idex_mem_read = mr;
        idex_rt = 5'(irt);
        branch_taken = br;
        mem_req = mq;
        mem_ready = mrdy;
    endtask

    task automatic idle();
        set_in(0, 1, 2, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_idex_bubble", int'(idex_bubble), 1);
        chk("rst_stall", int'(stall_cycles), 0);
        tick();
        idle();

        // Load-use: one stall cycle
        set_in(0, 8, 3, 0, 1, 8, 0, 0, 1);
        @(negedge clock);
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_ifid_write", int'(ifid_write), 0);
        chk("lu_idex_bubble", int'(idex_bubble), 1);
        tick();
        idle();
        @(negedge clock);
        chk("lu_stall_cnt", int'(stall_cycles), 1);
        tick();

        // Load into r0 is not a hazard
        set_in(0, 0, 0, 1, 1, 0, 0, 0, 1);
        @(negedge clock);
        chk("r0_pc_write", int'(pc_write), 1);
        chk("r0_idex_write", int'(idex_write), 1);
        tick();

        // Branch together with load-use
        do_reset();
        set_in(0, 9, 9, 1, 1, 9, 1, 0, 1);
        @(negedge clock);
        chk("br_flush", int'(ifid_flush), 1);
        chk("br_bubble", int'(idex_bubble), 1);
        chk("br_pc_write", int'(pc_write), 1);
        tick();
        idle();
        @(negedge clock);
        chk("br_flush_cnt", int'(flush_events), 1);
        chk("br_stall_cnt", int'(stall_cycles), 0);
        tick();

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 2, 0, 0, 0, 0, 1, 0);
            @(negedge clock);
            chk("mw_exmem_write", int'(exmem_write), 0);
            chk("mw_memwb_bubble", int'(memwb_bubble), 1);
            tick();
        end
        set_in(0, 1, 2, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        chk("mw_done_pc_write", int'(pc_write), 1);
        chk("mw_done_memwb", int'(memwb_bubble), 0);
        tick();
        idle();
        @(negedge clock);
        chk("mw_stall_cnt", int'(stall_cycles), 3);
        tick();

        // Timeout into ERROR
        do_reset();
        for (int i = 0; i < TMO + 1; i++) begin
            set_in(0, 1, 2, 0, 0, 0, 0, 1, 0);
            tick();
        end
        set_in(0, 1, 2, 0, 0, 0, 0, 1, 1);
        @(negedge clock);
        chk("to_mem_error", int'(mem_error), 1);
        chk("to_pc_write", int'(pc_write), 0);
        chk("to_stall_cnt", int'(stall_cycles), TMO + 1);
        tick();
        tick();
        @(negedge clock);
        chk("to_sticky", int'(mem_error), 1);
        tick();
        do_reset();
        @(negedge clock);
        chk("to_cleared", int'(mem_error), 0);
        chk("to_cnt_cleared", int'(stall_cycles), 0);
        tick();

        // Saturation of the stall counter
        do_reset();
        set_in(0, 7, 0, 0, 1, 7, 0, 0, 1);
        for (int i = 0; i < CMAX - 1; i++) tick();
        idle();
        @(negedge clock);
        chk("sat_pre", int'(stall_cycles), CMAX - 1);
        tick();
        set_in(0, 7, 0, 0, 1, 7, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        idle();
        @(negedge clock);
        chk("sat_hold", int'(stall_cycles), CMAX);
        tick();

        // Randomized traffic
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int rdy_pct;
            int req_pct;
            case ($urandom_range(0, 2))
                0: rdy_pct = 90;
                1: rdy_pct = 50;
                default: rdy_pct = 10;
            endcase
            req_pct = $urandom_range(20, 95);
            for (int c = 0; c < 50; c++) begin
                set_in($urandom_range(0, 99) < 2,
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       $urandom_range(0, 3),
                       $urandom_range(0, 99) < 20,
                       $urandom_range(0, 99) < req_pct,
                       $urandom_range(0, 99) < rdy_pct);
                tick();
            end
        end

        idle();
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
